// File: rtl/fp32_mult_sequencer.sv
// Operand-RAM to FP32-multiplier sequencer: reads operand pairs, issues them to a
// pipelined multiplier and writes the in-order results to a product RAM.
module fp32_mult_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] num_pairs,
  output logic              op_rd_en,
  output logic [ADDR_W:0]   op_rd_addr,
  input  logic [31:0]       op_rd_data,
  output logic              mul_start,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic              mul_done,
  input  logic [31:0]       mul_result,
  input  logic              mul_overflow,
  input  logic              mul_underflow,
  output logic              prod_wr_en,
  output logic [ADDR_W-1:0] prod_wr_addr,
  output logic [31:0]       prod_wr_data,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W:0]   ovf_count,
  output logic [ADDR_W:0]   unf_count,
  output logic              timeout_err,
  output logic              spurious_err
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StRdA, StRdB, StIssue, StDrain, StFin} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   np_q, iss_q, res_q, res_d;
  logic [WdW-1:0]      wd_q;
  logic [31:0]         a_q, b_q, wr_data_q;
  logic                start_q, wr_en_q, tmo_q, spur_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [CntW-1:0]     ovf_q, unf_q;
  logic                active, outstanding, done_ok, wd_hit;

  // Result acceptance, result-counter next state and watchdog expiry.
  always_comb begin
    active      = (state_q == StRdA) || (state_q == StRdB) ||
                  (state_q == StIssue) || (state_q == StDrain);
    outstanding = (res_q != iss_q);
    done_ok     = mul_done && (state_q != StIdle) && outstanding;
    res_d       = done_ok ? res_q + ADDR_W'(1) : res_q;
    wd_hit      = active && !mul_done && !start_q && outstanding &&
                  (wd_q == WdW'(TIMEOUT - 1));
  end

  // Sequencer FSM, capture path, flag counters, watchdog and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      np_q      <= '0;
      iss_q     <= '0;
      res_q     <= '0;
      wd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      start_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= '0;
      unf_q     <= '0;
      tmo_q     <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      wr_en_q <= 1'b0;

      if (done_ok) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= res_q;
        wr_data_q <= mul_result;
        if (mul_overflow)  ovf_q <= ovf_q + CntW'(1);
        if (mul_underflow) unf_q <= unf_q + CntW'(1);
      end
      if (mul_done && !done_ok) spur_q <= 1'b1;
      res_q <= res_d;

      // wd_q holds cycles elapsed since the last issue/result; the event cycle counts as one.
      if (!active || !outstanding)  wd_q <= '0;
      else if (mul_done || start_q) wd_q <= WdW'(1);
      else                          wd_q <= wd_q + WdW'(1);

      unique case (state_q)
        StIdle: begin
          if (go) begin
            np_q    <= num_pairs;
            iss_q   <= '0;
            res_q   <= '0;
            wd_q    <= '0;
            ovf_q   <= '0;
            unf_q   <= '0;
            tmo_q   <= 1'b0;
            state_q <= (num_pairs == '0) ? StFin : StRdA;
          end
        end
        StRdA: state_q <= StRdB;
        StRdB: begin
          a_q     <= op_rd_data;
          state_q <= StIssue;
        end
        StIssue: begin
          // Pulse appears next cycle, alongside the freshly registered b.
          b_q     <= op_rd_data;
          start_q <= 1'b1;
          iss_q   <= iss_q + ADDR_W'(1);
          state_q <= ((iss_q + ADDR_W'(1)) < np_q) ? StRdA : StDrain;
        end
        StDrain: if (res_d == np_q) state_q <= StFin;
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Abort: abandon outstanding results so late completions read as spurious.
      if (wd_hit) begin
        tmo_q   <= 1'b1;
        state_q <= StFin;
        start_q <= 1'b0;
        iss_q   <= iss_q;
        res_q   <= iss_q;
      end
    end
  end

  assign op_rd_en     = (state_q == StRdA) || (state_q == StRdB);
  assign op_rd_addr   = op_rd_en ? {iss_q, (state_q == StRdB)} : '0;
  assign mul_start    = start_q;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign prod_wr_en   = wr_en_q;
  assign prod_wr_addr = wr_addr_q;
  assign prod_wr_data = wr_data_q;
  assign busy         = (state_q != StIdle);
  assign finished     = (state_q == StFin);
  assign ovf_count    = ovf_q;
  assign unf_count    = unf_q;
  assign timeout_err  = tmo_q;
  assign spurious_err = spur_q;

endmodule

// File: tb/tb_fp32_mult_sequencer.sv
// Scoreboard bench for fp32_mult_sequencer with operand RAM and multiplier models.
module tb_fp32_mult_sequencer;
  localparam int AW  = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [AW-1:0] num_pairs = '0;
  logic          op_rd_en;
  logic [AW:0]   op_rd_addr;
  logic [31:0]   op_rd_data = '0;
  logic          mul_start;
  logic [31:0]   mul_a, mul_b;
  logic          mul_done = 1'b0;
  logic [31:0]   mul_result = '0;
  logic          mul_overflow = 1'b0, mul_underflow = 1'b0;
  logic          prod_wr_en;
  logic [AW-1:0] prod_wr_addr;
  logic [31:0]   prod_wr_data;
  logic          busy, finished, timeout_err, spurious_err;
  logic [AW:0]   ovf_count, unf_count;

  fp32_mult_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .go(go), .num_pairs(num_pairs),
    .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr), .op_rd_data(op_rd_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
    .prod_wr_en(prod_wr_en), .prod_wr_addr(prod_wr_addr), .prod_wr_data(prod_wr_data),
    .busy(busy), .finished(finished), .ovf_count(ovf_count), .unf_count(unf_count),
    .timeout_err(timeout_err), .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Truncating FP32 multiply; returns {overflow, underflow, result}. Zero/denormal inputs give +0.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return 34'h0;
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e > 254) return {2'b10, s, 8'hFF, 23'h0};
    if (e < 1)   return {2'b01, s, 31'h0};
    return {2'b00, s, e[7:0], m};
  endfunction

  always @(posedge clk) ncyc++;

  // Operand RAM: one-cycle read latency.
  logic [31:0] op_mem [32];
  always @(posedge clk) if (op_rd_en) op_rd_data <= op_mem[op_rd_addr];

  // In-order multiplier model with programmable latency; done can be disabled or injected.
  typedef struct {logic [31:0] r; logic o; logic u; int due;} pend_t;
  pend_t       pq[$];
  pend_t       pe;
  logic [33:0] fr;
  int          mul_lat = 4;
  bit          mul_en = 1'b1;
  bit          inj = 1'b0;
  always @(negedge clk) begin
    mul_done = 1'b0; mul_result = '0; mul_overflow = 1'b0; mul_underflow = 1'b0;
    if (inj) begin
      mul_done = 1'b1; mul_result = 32'hDEADBEEF; inj = 1'b0;
    end else if (mul_en && pq.size() > 0 && pq[0].due <= ncyc) begin
      pe = pq.pop_front();
      mul_done = 1'b1; mul_result = pe.r; mul_overflow = pe.o; mul_underflow = pe.u;
    end
    if (mul_start) begin
      fr = fmul(mul_a, mul_b);
      pq.push_back('{fr[31:0], fr[33], fr[32], ncyc + mul_lat});
    end
  end

  // Scoreboard monitor and event counters.
  typedef struct {logic [AW-1:0] addr; logic [31:0] data;} exp_t;
  exp_t        exp_q[$];
  exp_t        ex;
  logic [31:0] prod_mem [16];
  int fin_cnt = 0, rd_cnt = 0, start_cnt = 0, gap_bad = 0, last_start = 0, tmo_cyc = -1;
  logic tmo_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prod_wr_en) begin
        prod_mem[prod_wr_addr] = prod_wr_data;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL stray_write: got addr=%0d data=%h, required no write", prod_wr_addr,
                   prod_wr_data);
        end else begin
          ex = exp_q.pop_front();
          chk("wr_addr", 64'(prod_wr_addr), 64'(ex.addr));
          chk("wr_data", 64'(prod_wr_data), 64'(ex.data));
        end
      end
      if (finished) fin_cnt++;
      if (op_rd_en) rd_cnt++;
      if (mul_start) begin
        if (start_cnt > 0 && ncyc - last_start != 3) gap_bad++;
        start_cnt++;
        last_start = ncyc;
      end
      if (timeout_err && !tmo_prev) tmo_cyc = ncyc;
      tmo_prev = timeout_err;
    end
  end

  task automatic clr_counts();
    fin_cnt = 0; rd_cnt = 0; start_cnt = 0; gap_bad = 0; tmo_cyc = -1;
  endtask

  task automatic run(input int n, input int hold);
    int eo = 0, eu = 0;
    logic [33:0] f;
    for (int i = 0; i < n; i++) begin
      f = fmul(op_mem[2*i], op_mem[2*i+1]);
      exp_q.push_back('{AW'(i), f[31:0]});
      eo += int'(f[33]);
      eu += int'(f[32]);
    end
    clr_counts();
    @(negedge clk);
    go = 1'b1;
    num_pairs = AW'(n);
    repeat (hold) @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 2000 && fin_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("finished_once", 64'(fin_cnt), 64'd1);
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    chk("start_count", 64'(start_cnt), 64'(n));
    chk("rd_count", 64'(rd_cnt), 64'(2 * n));
    chk("start_spacing", 64'(gap_bad), 64'd0);
    chk("ovf_count", 64'(ovf_count), 64'(eo));
    chk("unf_count", 64'(unf_count), 64'(eu));
    chk("no_timeout", 64'(timeout_err), 64'd0);
    chk("no_spurious", 64'(spurious_err), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  function automatic logic any_out();
    return |{op_rd_en, op_rd_addr, mul_start, mul_a, mul_b, prod_wr_en, prod_wr_addr,
             prod_wr_data, busy, finished, ovf_count, unf_count, timeout_err, spurious_err};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) op_mem[i] = '0;
    for (int i = 0; i < 16; i++) prod_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(any_out()), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single pair 2.0 * 3.0.
    op_mem[0] = 32'h40000000; op_mem[1] = 32'h40400000;
    run(1, 1);
    chk("prod0_single", 64'(prod_mem[0]), 64'h40C00000);

    // Three pairs, go held high while busy.
    op_mem[0] = 32'h40000000; op_mem[1] = 32'h40400000;
    op_mem[2] = 32'h3FC00000; op_mem[3] = 32'hC0000000;
    op_mem[4] = 32'h3F800000; op_mem[5] = 32'h00000000;
    for (int i = 0; i < 3; i++) prod_mem[i] = 32'h12345678;
    run(3, 5);
    chk("prod0", 64'(prod_mem[0]), 64'h40C00000);
    chk("prod1", 64'(prod_mem[1]), 64'hC0400000);
    chk("prod2", 64'(prod_mem[2]), 64'h00000000);

    // Overflow and underflow pair.
    op_mem[0] = 32'h7F000000; op_mem[1] = 32'h7F000000;
    op_mem[2] = 32'h00800000; op_mem[3] = 32'h00800000;
    run(2, 1);
    chk("ovf_exact", 64'(ovf_count), 64'd1);
    chk("unf_exact", 64'(unf_count), 64'd1);

    // Empty run, go held through FIN.
    run(0, 2);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) op_mem[i] = $urandom();
      mul_lat = int'($urandom_range(1, 8));
      run(int'($urandom_range(1, 15)), 1);
    end

    // Watchdog: multiplier never completes.
    mul_lat = 4;
    mul_en = 1'b0;
    clr_counts();
    @(negedge clk);
    go = 1'b1; num_pairs = AW'(2);
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 500 && fin_cnt == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("timeout_set", 64'(timeout_err), 64'd1);
    chk("timeout_delay", 64'(tmo_cyc - last_start), 64'(TMO));
    chk("timeout_finished", 64'(fin_cnt), 64'd1);
    chk("timeout_starts", 64'(start_cnt), 64'd2);
    chk("pre_spurious", 64'(spurious_err), 64'd0);
    pq.delete();
    mul_en = 1'b1;
    inj = 1'b1;
    repeat (3) @(negedge clk);
    chk("spurious_set", 64'(spurious_err), 64'd1);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);

    // Reset mid-drain, then a clean run.
    for (int i = 0; i < 32; i++) op_mem[i] = $urandom();
    mul_lat = 20;
    @(negedge clk);
    go = 1'b1; num_pairs = AW'(2);
    @(negedge clk);
    go = 1'b0;
    repeat (11) @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    chk("no_write_before_rst", 64'(prod_wr_en), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_run_outputs", 64'(any_out()), 64'd0);
    pq.delete();
    @(negedge clk);
    pq.delete();
    rst = 1'b0;
    mul_lat = 3;
    run(3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
